// File: rtl/hdmi_period_scheduler.sv
// ---------------------------------------------------------------------------
// hdmi_period_scheduler
// Pixel timing and TMDS period generator for the HDMI transmitter. Produces
// the raster counters, registered syncs, the per-pixel period mode and the
// control/preamble bits for the three TMDS channels. In horizontal blanking it
// schedules a data island of 1..MAX_PACKETS packets, pulling packets from an
// upstream source through a valid/ack handshake.
// ---------------------------------------------------------------------------
module hdmi_period_scheduler #(
    parameter int H_TOTAL          = 800,
    parameter int V_TOTAL          = 525,
    parameter int H_ACTIVE         = 640,
    parameter int V_ACTIVE         = 480,
    parameter int H_SYNC_START     = 16,
    parameter int H_SYNC_WIDTH     = 96,
    parameter int V_SYNC_START     = 0,
    parameter int V_SYNC_WIDTH     = 2,
    parameter int SYNC_ACTIVE_HIGH = 0,
    parameter int ISLAND_START     = 10,
    parameter int MAX_PACKETS      = 18,
    parameter int DVI_OUTPUT       = 0,
    parameter int BIT_WIDTH        = $clog2(H_TOTAL) - 1,
    parameter int BIT_HEIGHT       = $clog2(V_TOTAL) - 1
) (
    input  logic                clk_pixel,
    input  logic                reset_n,
    input  logic                packet_valid,
    output logic [BIT_WIDTH:0]  cx,
    output logic [BIT_HEIGHT:0] cy,
    output logic                hsync,
    output logic                vsync,
    output logic [2:0]          mode,
    output logic [3:0]          ctl,
    output logic [4:0]          packet_index,
    output logic                island_first,
    output logic                packet_ack
);

    // TMDS period encoding seen by the channel encoders
    typedef enum logic [2:0] {
        MODE_CTRL   = 3'd0,
        MODE_VIDEO  = 3'd1,
        MODE_VGUARD = 3'd2,
        MODE_DATA   = 3'd3,
        MODE_DGUARD = 3'd4
    } mode_t;

    // Island sequencer; S_PKT_END is the cycle in which the ack is visible
    // upstream and the continue/stop decision for the next pixel is taken
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_LGUARD,
        S_PACKET,
        S_PKT_END,
        S_TGUARD
    } state_t;

    localparam int CW = BIT_WIDTH + 1;
    localparam int CH = BIT_HEIGHT + 1;

    localparam logic [CW-1:0] CX_LAST = CW'(H_TOTAL - 1);
    localparam logic [CH-1:0] CY_LAST = CH'(V_TOTAL - 1);

    // First active pixel / line of the frame
    localparam logic [31:0] SCREEN_START_X = 32'(H_TOTAL - H_ACTIVE);
    localparam logic [31:0] SCREEN_START_Y = 32'(V_TOTAL - V_ACTIVE);

    // Video preamble and guard band sit immediately before screen_start_x
    localparam logic [31:0] VPRE_FIRST   = SCREEN_START_X - 32'd10;
    localparam logic [31:0] VPRE_LAST    = SCREEN_START_X - 32'd3;
    localparam logic [31:0] VGUARD_FIRST = SCREEN_START_X - 32'd2;

    // Exclusive end cx an island may reach: on active lines it must leave
    // room for the video preamble and guard, on blanking lines for the wrap
    localparam logic [31:0] LIMIT_ACTIVE = SCREEN_START_X - 32'd14;
    localparam logic [31:0] LIMIT_BLANK  = 32'(H_TOTAL - 4);

    // Shortest island: 8 preamble + 2 guard + 32 data + 2 guard
    localparam logic [31:0] ISLAND_X     = 32'(ISLAND_START);
    localparam logic [31:0] MIN_ISL_END  = 32'(ISLAND_START + 44);

    localparam logic [31:0] HS_FIRST     = 32'(H_SYNC_START);
    localparam logic [31:0] HS_END       = 32'(H_SYNC_START + H_SYNC_WIDTH);
    localparam logic [31:0] VS_FIRST     = 32'(V_SYNC_START);
    localparam logic [31:0] VS_END       = 32'(V_SYNC_START + V_SYNC_WIDTH);

    localparam logic [31:0] MAX_PKTS     = 32'(MAX_PACKETS);
    localparam logic        SYNC_ON      = (SYNC_ACTIVE_HIGH != 0);
    localparam logic        ISLANDS_ON   = (DVI_OUTPUT == 0);

    state_t       state;
    state_t       pix_state;
    logic [4:0]   cnt;
    logic [4:0]   pix_cnt;
    logic [4:0]   pkts_sent;

    logic [31:0]  cx_w;
    logic [31:0]  cy_w;
    logic         active_line;
    logic [31:0]  limit;
    logic         island_go;
    logic         more_packets;
    logic         hsync_on;
    logic         vsync_on;
    mode_t        video_mode;
    logic [3:0]   video_ctl;

    assign cx_w = 32'(cx);
    assign cy_w = 32'(cy);

    assign active_line = (cy_w >= SCREEN_START_Y);
    assign limit       = active_line ? LIMIT_ACTIVE : LIMIT_BLANK;

    // An island opens only if its minimum length fits before the limit
    assign island_go = ISLANDS_ON && (cx_w == ISLAND_X) && packet_valid
                       && (MIN_ISL_END <= limit);

    // In S_PKT_END cx is the would-be first pixel of the next packet; that
    // packet plus the trailing guard must end by the limit
    assign more_packets = packet_valid && (32'(pkts_sent) < MAX_PKTS)
                          && ((cx_w + 32'd34) <= limit);

    assign hsync_on = (cx_w >= HS_FIRST) && (cx_w < HS_END);
    assign vsync_on = (cy_w >= VS_FIRST) && (cy_w < VS_END);

    // Resolve which island phase the current pixel belongs to
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch
        pix_state = state;
        pix_cnt   = cnt;
        case (state)
            S_IDLE: begin
                pix_cnt = 5'd0;
                if (island_go) begin
                    pix_state = S_PREAMBLE;
                end
            end
            S_PKT_END: begin
                pix_cnt   = 5'd0;
                pix_state = more_packets ? S_PACKET : S_TGUARD;
            end
            default: ;
        endcase
    end

    // Video-period decode used whenever no island owns the pixel
    always_comb begin
        video_mode = MODE_CTRL;
        video_ctl  = 4'b0000;
        if (active_line) begin
            if (cx_w >= SCREEN_START_X) begin
                video_mode = MODE_VIDEO;
            end else if (cx_w >= VGUARD_FIRST) begin
                video_mode = ISLANDS_ON ? MODE_VGUARD : MODE_CTRL;
            end else if ((cx_w >= VPRE_FIRST) && (cx_w <= VPRE_LAST)) begin
                video_ctl = ISLANDS_ON ? 4'b0001 : 4'b0000;
            end
        end
    end

    // Raster counters: cx wraps every line, cy advances on each cx wrap
    always_ff @(posedge clk_pixel) begin
        // NOTE: reset_n is synchronous, so it only takes effect on an edge
        if (!reset_n) begin
            cx <= '0;
            cy <= '0;
        end else if (cx == CX_LAST) begin
            // NOTE: non-blocking everywhere in sequential logic, so cy sees
            // the pre-edge cx and no ordering races exist between blocks
            cx <= '0;
            cy <= (cy == CY_LAST) ? '0 : cy + CH'(1);
        end else begin
            cx <= cx + CW'(1);
        end
    end

    // Registered syncs, aligned with the other per-pixel outputs
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            hsync <= ~SYNC_ON;
            vsync <= ~SYNC_ON;
        end else begin
            hsync <= SYNC_ON ? hsync_on : ~hsync_on;
            vsync <= SYNC_ON ? vsync_on : ~vsync_on;
        end
    end

    // Island sequencer with registered period outputs for the current pixel
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= 5'd0;
            pkts_sent    <= 5'd0;
            mode         <= MODE_CTRL;
            ctl          <= 4'b0000;
            packet_index <= 5'd0;
            island_first <= 1'b0;
            packet_ack   <= 1'b0;
        end else begin
            mode         <= video_mode;
            ctl          <= video_ctl;
            packet_index <= 5'd0;
            island_first <= 1'b0;
            packet_ack   <= 1'b0;

            case (pix_state)
                S_PREAMBLE: begin
                    mode <= MODE_CTRL;
                    ctl  <= 4'b0101;
                    if (pix_cnt == 5'd7) begin
                        state <= S_LGUARD;
                        cnt   <= 5'd0;
                    end else begin
                        state <= S_PREAMBLE;
                        cnt   <= pix_cnt + 5'd1;
                    end
                end

                S_LGUARD: begin
                    mode <= MODE_DGUARD;
                    ctl  <= 4'b0000;
                    if (pix_cnt == 5'd1) begin
                        state     <= S_PACKET;
                        cnt       <= 5'd0;
                        pkts_sent <= 5'd0;
                    end else begin
                        state <= S_LGUARD;
                        cnt   <= pix_cnt + 5'd1;
                    end
                end

                S_PACKET: begin
                    mode         <= MODE_DATA;
                    ctl          <= 4'b0000;
                    packet_index <= pix_cnt;
                    island_first <= (pix_cnt == 5'd0) && (pkts_sent == 5'd0);
                    if (pix_cnt == 5'd31) begin
                        // Ack becomes visible next cycle, which is also when
                        // packet_valid is sampled for the following packet
                        packet_ack <= 1'b1;
                        pkts_sent  <= pkts_sent + 5'd1;
                        state      <= S_PKT_END;
                        cnt        <= 5'd0;
                    end else begin
                        state <= S_PACKET;
                        cnt   <= pix_cnt + 5'd1;
                    end
                end

                S_TGUARD: begin
                    mode <= MODE_DGUARD;
                    ctl  <= 4'b0000;
                    if (pix_cnt == 5'd1) begin
                        state <= S_IDLE;
                        cnt   <= 5'd0;
                    end else begin
                        state <= S_TGUARD;
                        cnt   <= pix_cnt + 5'd1;
                    end
                end

                default: begin
                    // Idle pixel: video decode already applied above
                    state <= S_IDLE;
                    cnt   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hdmi_period_scheduler
// Directed bench: default 640x480 timing instance plus a small-frame DVI
// instance with active-high syncs. Outputs are sampled 1 time unit after
// the rising edge; at that point they describe the pixel the counters held
// before the edge (pcx/pcy).
// ---------------------------------------------------------------------------
module tb_hdmi_period_scheduler;

    logic clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    logic       reset_n;
    logic       packet_valid;

    logic [9:0] cx;
    logic [9:0] cy;
    logic       hsync, vsync;
    logic [2:0] mode;
    logic [3:0] ctl;
    logic [4:0] packet_index;
    logic       island_first, packet_ack;

    logic [7:0] dcx;
    logic [2:0] dcy;
    logic       dhsync, dvsync;
    logic [2:0] dmode;
    logic [3:0] dctl;
    logic [4:0] didx;
    logic       dfirst, dack;

    hdmi_period_scheduler dut (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .packet_valid (packet_valid),
        .cx           (cx),
        .cy           (cy),
        .hsync        (hsync),
        .vsync        (vsync),
        .mode         (mode),
        .ctl          (ctl),
        .packet_index (packet_index),
        .island_first (island_first),
        .packet_ack   (packet_ack)
    );

    hdmi_period_scheduler #(
        .H_TOTAL          (200),
        .V_TOTAL          (8),
        .H_ACTIVE         (100),
        .V_ACTIVE         (4),
        .H_SYNC_START     (4),
        .H_SYNC_WIDTH     (10),
        .V_SYNC_START     (1),
        .V_SYNC_WIDTH     (2),
        .SYNC_ACTIVE_HIGH (1),
        .DVI_OUTPUT       (1)
    ) dut_dvi (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .packet_valid (packet_valid),
        .cx           (dcx),
        .cy           (dcy),
        .hsync        (dhsync),
        .vsync        (dvsync),
        .mode         (dmode),
        .ctl          (dctl),
        .packet_index (didx),
        .island_first (dfirst),
        .packet_ack   (dack)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int pcx = 0, pcy = 0, pdx = 0, pdy = 0;

    logic [2:0] cap_mode  [0:799];
    logic [3:0] cap_ctl   [0:799];
    logic [4:0] cap_idx   [0:799];
    logic       cap_ack   [0:799];
    logic       cap_first [0:799];

    // DVI monitor tallies, inspected by the main sequence
    logic dvi_mon = 1'b0;
    int   dvi_samples = 0, dvi_bad_mode = 0, dvi_bad_ctl = 0, dvi_acks = 0;

    always @(negedge clk_pixel) begin
        if (dvi_mon) begin
            dvi_samples++;
            if (dmode > 3'd1)   dvi_bad_mode++;
            if (dctl != 4'd0)   dvi_bad_ctl++;
            if (dack)           dvi_acks++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        pcx = 32'(cx);
        pcy = 32'(cy);
        pdx = 32'(dcx);
        pdy = 32'(dcy);
        @(posedge clk_pixel);
        #1;
    endtask

    // Advance until the outputs describe default-instance pixel (x,y)
    task automatic go_to(input int x, input int y);
        int n = 0;
        while (!(pcx == x && pcy == y) && n < 50000) begin
            tick();
            n++;
        end
        check($sformatf("reach_%0d_%0d", x, y), 32'(pcy * 1024 + pcx), 32'(y * 1024 + x));
    endtask

    // Same for the DVI instance
    task automatic go_to_d(input int x, input int y);
        int n = 0;
        while (!(pdx == x && pdy == y) && n < 5000) begin
            tick();
            n++;
        end
        check($sformatf("dvi_reach_%0d_%0d", x, y), 32'(pdy * 256 + pdx), 32'(y * 256 + x));
    endtask

    // Record one full line y; optionally drop packet_valid after n acks
    task automatic capture_line(input int y, input int drop_after);
        int acks = 0;
        logic [9:0] px;
        go_to(799, y - 1);
        for (int i = 0; i < 800; i++) begin
            tick();
            px = pcx[9:0];
            cap_mode[px]  = mode;
            cap_ctl[px]   = ctl;
            cap_idx[px]   = packet_index;
            cap_ack[px]   = packet_ack;
            cap_first[px] = island_first;
            if (packet_ack) begin
                acks++;
                if (acks == drop_after) packet_valid = 1'b0;
            end
        end
    endtask

    // Compare a captured line with the expected period layout.
    // isl_end = exclusive end cx of the island (0 = no island).
    task automatic check_line(input string tag, input int isl_end, input bit active, input int n_acks);
        int em = 0, ec = 0, ei = 0, na = 0, bad_ack = 0, nf = 0, first_x = -1;
        logic [2:0] m_x;
        logic [3:0] c_x;
        logic [4:0] i_x;
        bit         data_x;
        for (int x = 0; x < 800; x++) begin
            m_x = 3'd0; c_x = 4'd0; i_x = 5'd0; data_x = 1'b0;
            if (isl_end > 0 && x >= 10 && x < isl_end) begin
                if (x <= 17)                c_x = 4'b0101;
                else if (x <= 19)           m_x = 3'd4;
                else if (x >= isl_end - 2)  m_x = 3'd4;
                else begin
                    m_x = 3'd3;
                    data_x = 1'b1;
                    i_x = 5'((x - 20) % 32);
                end
            end else if (active) begin
                if (x >= 160)                  m_x = 3'd1;
                else if (x >= 158)             m_x = 3'd2;
                else if (x >= 150 && x <= 157) c_x = 4'b0001;
            end
            if (cap_mode[x[9:0]] !== m_x) em++;
            if (cap_ctl[x[9:0]]  !== c_x) ec++;
            if (cap_idx[x[9:0]]  !== i_x) ei++;
            if (cap_ack[x[9:0]]) begin
                na++;
                if (!(data_x && i_x == 5'd31)) bad_ack++;
            end
            if (cap_first[x[9:0]]) begin
                nf++;
                first_x = x;
            end
        end
        check({tag, "_mode_errs"}, 32'(em), 32'd0);
        check({tag, "_ctl_errs"},  32'(ec), 32'd0);
        check({tag, "_idx_errs"},  32'(ei), 32'd0);
        check({tag, "_acks"},      32'(na), 32'(n_acks));
        check({tag, "_ack_pos"},   32'(bad_ack), 32'd0);
        check({tag, "_first_cnt"}, 32'(nf), (isl_end > 0) ? 32'd1 : 32'd0);
        check({tag, "_first_x"},   32'(first_x), (isl_end > 0) ? 32'd20 : 32'hFFFF_FFFF);
    endtask

    initial begin
        int acks;
        int n;

        // ---- reset ----
        reset_n = 1'b0;
        packet_valid = 1'b0;
        repeat (3) tick();
        check("rst_cx", 32'(cx), 32'd0);
        check("rst_cy", 32'(cy), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_ctl", 32'(ctl), 32'd0);
        check("rst_idx", 32'(packet_index), 32'd0);
        check("rst_first", 32'(island_first), 32'd0);
        check("rst_ack", 32'(packet_ack), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_dvi_hsync", 32'(dhsync), 32'd0);
        check("rst_dvi_vsync", 32'(dvsync), 32'd0);

        // ---- free run: counters, sync windows, one-cycle lag ----
        reset_n = 1'b1;
        tick();
        check("lag_cx", 32'(cx), 32'd1);
        check("lag_vsync_px0", 32'(vsync), 32'd0);
        check("lag_hsync_px0", 32'(hsync), 32'd1);
        go_to(15, 0);
        check("hsync_15", 32'(hsync), 32'd1);
        tick();
        check("hsync_16", 32'(hsync), 32'd0);
        go_to(111, 0);
        check("hsync_111", 32'(hsync), 32'd0);
        tick();
        check("hsync_112", 32'(hsync), 32'd1);
        go_to(799, 0);
        check("wrap_cx", 32'(cx), 32'd0);
        check("wrap_cy", 32'(cy), 32'd1);
        check("vsync_line0", 32'(vsync), 32'd0);
        go_to(799, 1);
        check("vsync_line1", 32'(vsync), 32'd0);
        check("wrap_cy2", 32'(cy), 32'd2);
        tick();
        check("vsync_line2", 32'(vsync), 32'd1);

        // ---- small DVI frame: active-high syncs and frame wrap ----
        go_to_d(199, 0);
        check("dvi_wrap_cx", 32'(dcx), 32'd0);
        check("dvi_wrap_cy", 32'(dcy), 32'd1);
        go_to_d(3, 1);
        check("dvi_hsync_3", 32'(dhsync), 32'd0);
        check("dvi_vsync_1", 32'(dvsync), 32'd1);
        go_to_d(4, 1);
        check("dvi_hsync_4", 32'(dhsync), 32'd1);
        go_to_d(13, 1);
        check("dvi_hsync_13", 32'(dhsync), 32'd1);
        go_to_d(14, 1);
        check("dvi_hsync_14", 32'(dhsync), 32'd0);
        go_to_d(0, 3);
        check("dvi_vsync_3", 32'(dvsync), 32'd0);
        go_to_d(99, 4);
        check("dvi_no_vguard", 32'(dmode), 32'd0);
        go_to_d(100, 4);
        check("dvi_video", 32'(dmode), 32'd1);
        go_to_d(199, 7);
        check("dvi_frame_cx", 32'(dcx), 32'd0);
        check("dvi_frame_cy", 32'(dcy), 32'd0);

        // ---- valid held high: full island on blanking line 10 ----
        go_to(100, 9);
        packet_valid = 1'b1;
        dvi_mon = 1'b1;
        capture_line(10, 0);
        check_line("l10", 598, 1'b0, 18);
        check("l10_ctl10", 32'(cap_ctl[10]), 32'd5);
        check("l10_ctl17", 32'(cap_ctl[17]), 32'd5);
        check("l10_mode19", 32'(cap_mode[19]), 32'd4);
        check("l10_mode20", 32'(cap_mode[20]), 32'd3);
        check("l10_idx51", 32'(cap_idx[51]), 32'd31);
        check("l10_mode595", 32'(cap_mode[595]), 32'd3);
        check("l10_mode597", 32'(cap_mode[597]), 32'd4);
        check("l10_mode598", 32'(cap_mode[598]), 32'd0);

        // ---- valid held high: active line, island cut by the limit ----
        go_to(799, 44);
        capture_line(45, 0);
        check_line("l45", 118, 1'b1, 3);
        check("l45_mode115", 32'(cap_mode[115]), 32'd3);
        check("l45_mode116", 32'(cap_mode[116]), 32'd4);
        check("l45_mode118", 32'(cap_mode[118]), 32'd0);
        check("l45_ctl150", 32'(cap_ctl[150]), 32'd1);
        check("l45_ctl157", 32'(cap_ctl[157]), 32'd1);
        check("l45_mode158", 32'(cap_mode[158]), 32'd2);
        check("l45_mode160", 32'(cap_mode[160]), 32'd1);
        check("l45_mode799", 32'(cap_mode[799]), 32'd1);

        // DVI instance saw valid high for far more than a whole frame
        packet_valid = 1'b0;
        dvi_mon = 1'b0;
        check("dvi_frame_covered", 32'(dvi_samples >= 1600), 32'd1);
        check("dvi_bad_mode", 32'(dvi_bad_mode), 32'd0);
        check("dvi_bad_ctl", 32'(dvi_bad_ctl), 32'd0);
        check("dvi_acks", 32'(dvi_acks), 32'd0);

        // ---- valid low at cx 10: no island ----
        capture_line(46, 0);
        check_line("l46", 0, 1'b1, 0);

        // ---- valid dropped after the 2nd ack: 2-packet island ----
        packet_valid = 1'b1;
        capture_line(47, 2);
        check_line("l47", 86, 1'b1, 2);
        check("l47_mode83", 32'(cap_mode[83]), 32'd3);
        check("l47_mode84", 32'(cap_mode[84]), 32'd4);
        check("l47_mode85", 32'(cap_mode[85]), 32'd4);
        check("l47_mode86", 32'(cap_mode[86]), 32'd0);

        // ---- reset mid-packet at cx 30 ----
        packet_valid = 1'b1;
        go_to(29, 48);
        check("pre_rst_mode", 32'(mode), 32'd3);
        check("pre_rst_idx", 32'(packet_index), 32'd9);
        reset_n = 1'b0;
        tick();
        check("mid_rst_cx", 32'(cx), 32'd0);
        check("mid_rst_cy", 32'(cy), 32'd0);
        check("mid_rst_mode", 32'(mode), 32'd0);
        check("mid_rst_ctl", 32'(ctl), 32'd0);
        check("mid_rst_idx", 32'(packet_index), 32'd0);
        check("mid_rst_first", 32'(island_first), 32'd0);
        check("mid_rst_ack", 32'(packet_ack), 32'd0);
        check("mid_rst_hsync", 32'(hsync), 32'd1);
        check("mid_rst_vsync", 32'(vsync), 32'd1);
        reset_n = 1'b1;
        tick();
        check("resume_cx", 32'(cx), 32'd1);
        check("resume_cy", 32'(cy), 32'd0);
        acks = 0;
        n = 0;
        while (pcx != 20 && n < 100) begin
            tick();
            if (packet_ack) acks++;
            n++;
        end
        check("resume_reach20", 32'(pcx), 32'd20);
        check("resume_no_ack", 32'(acks), 32'd0);
        check("resume_island_mode", 32'(mode), 32'd3);
        check("resume_island_first", 32'(island_first), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
- Parametrised timing and period generator for the HDMI transmitter. It produces the pixel counters, sync signals, TMDS period mode, and control/preamble bits that drive the three tmds_channel instances.
- Generalises the fixed-format timing to arbitrary frame geometry and sync polarity.
- Schedules variable-length data islands (1..MAX_PACKETS packets) in horizontal blanking on every line, using a valid/ack handshake with an upstream packet source.

Parameters:
- H_TOTAL, 800, total pixels per line
- V_TOTAL, 525, total lines per frame
- H_ACTIVE, 640, active pixels; active region is cx >= H_TOTAL-H_ACTIVE (screen_start_x)
- V_ACTIVE, 480, active lines; active region is cy >= V_TOTAL-V_ACTIVE
- H_SYNC_START, 16, hsync asserted for cx in [H_SYNC_START, H_SYNC_START+H_SYNC_WIDTH-1]
- H_SYNC_WIDTH, 96, hsync width in pixels
- V_SYNC_START, 0, vsync asserted for cy in [V_SYNC_START, V_SYNC_START+V_SYNC_WIDTH-1]
- V_SYNC_WIDTH, 2, vsync width in lines
- SYNC_ACTIVE_HIGH, 0, 1 = syncs assert high; 0 = syncs assert low
- ISLAND_START, 10, cx of the first data-island preamble pixel
- MAX_PACKETS, 18, maximum packets per island (1..18)
- DVI_OUTPUT, 0, 1 = never emit preambles, guards or islands
- BIT_WIDTH, $clog2(H_TOTAL)-1, cx is [BIT_WIDTH:0]
- BIT_HEIGHT, $clog2(V_TOTAL)-1, cy is [BIT_HEIGHT:0]

Ports:
- clk_pixel  in  1  pixel clock
- reset_n  in  1  synchronous, active-low reset
- packet_valid  in  1  upstream has a packet ready; held until packet_ack
- cx  out  BIT_WIDTH+1  horizontal counter
- cy  out  BIT_HEIGHT+1  vertical counter
- hsync  out  1  registered, polarity per SYNC_ACTIVE_HIGH
- vsync  out  1  registered, polarity per SYNC_ACTIVE_HIGH
- mode  out  3  0 control, 1 video, 2 video guard, 3 island data, 4 island guard
- ctl  out  4  {ctl3,ctl2,ctl1,ctl0}
- packet_index  out  5  pixel index 0..31 within the current packet
- island_first  out  1  high on the first island-data pixel only
- packet_ack  out  1  1-cycle pulse on pixel 31 of each packet

Behaviour:
- Reset: when reset_n=0 at a clk_pixel edge, the next cycle shows:
  - cx=0, cy=0, FSM IDLE
  - mode=0, ctl=0, packet_index=0, island_first=0, packet_ack=0
  - hsync and vsync at their deasserted level
- Reset takes priority over every other event. An island in progress is abandoned and no ack is issued for a partial packet.
- Counters: cx increments and wraps H_TOTAL-1 -> 0. cy increments only when cx wraps, and wraps V_TOTAL-1 -> 0.
- Latency: every output other than cx/cy is registered. The value for counter position x appears on the cycle after cx==x.
- Video period (active lines only):
  - preamble at cx in [screen_start_x-10, screen_start_x-3]: mode 0, ctl=0001
  - guard at cx in [screen_start_x-2, screen_start_x-1]: mode 2
  - video at cx >= screen_start_x: mode 1
  - all other pixels: mode 0, ctl=0000
- Island limit, in exclusive end cx:
  - active lines: LIMIT = screen_start_x-14
  - blanking lines: LIMIT = H_TOTAL-4
- Island length: an island of k packets spans 12+32k pixels from ISLAND_START.
- FSM states and transitions:
  - IDLE -> PREAMBLE at cx==ISLAND_START, only if packet_valid=1 and ISLAND_START+44 <= LIMIT.
  - PREAMBLE: 8 pixels, mode 0, ctl=0101.
  - LGUARD: 2 pixels, mode 4.
  - PACKET: 32 pixels, mode 3, packet_index counts 0..31; packet_ack pulses on index 31.
  - At the end of a packet, PACKET repeats only if all hold: packet_valid=1 at index 31, packets_sent < MAX_PACKETS, and the next packet's end+2 <= LIMIT. Otherwise -> TGUARD.
  - TGUARD: 2 pixels, mode 4, then -> IDLE.
- Handshake: packet_valid sampled low at index 31 means the island ends after the current packet. Deasserting packet_valid mid-packet is an upstream violation; the scheduler continues the packet unchanged.
- Island sync: hsync and vsync continue to follow the counters throughout an island.
- DVI_OUTPUT=1: mode is only ever 0 or 1, ctl is held at 0, packet_ack is never asserted, and the FSM stays in IDLE.
- Priority: island states override the video-period decode. The LIMIT rule prevents any overlap.

Test Plan:
- Defaults, reset then free-run 2 frames:
  - cx wraps 799->0 with cy+1; cy wraps 524->0
  - hsync low exactly for cx 16..111; vsync low for cy 0..1
  - every output lags cx by 1 cycle
- packet_valid held high, blanking line cy=10:
  - ctl=0101 at cx 10..17; mode 4 at 18..19
  - mode 3 at 20..595 with 18 packet_ack pulses; island_first only at 20
  - mode 4 at 596..597, then mode 0
- packet_valid held high, active line cy=100:
  - 3 packets at cx 20..115; guard at 116..117
  - ctl=0001 at 150..157; mode 2 at 158..159; mode 1 at 160..799
- packet_valid low at cx 10: no island on that line. Separately, packet_valid dropped after the 2nd ack: island of 2 packets, trailing guard at cx 84..85.
- DVI_OUTPUT=1 with packet_valid=1: over one frame, mode takes only 0/1, ctl=0, and there are zero acks.
- reset_n low for 1 cycle at cx 30 mid-packet: next cycle shows all reset values and no packet_ack; counting resumes from cx=0, cy=0.
